// File: rtl/gf163_result_collector_pkg.sv
// ============================================================================
//  Module   : gf163_result_collector_pkg
//  Purpose  : Shared constants and FSM state encoding for the GF(2^163)
//             result collector (word deserialiser behind the multiplier).
//  Contents : WORD_W, NWORDS, M, PAD, FRAME_W, counter widths, state_t.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

package gf163_result_collector_pkg;

   localparam int WORD_W  = 32;               // incoming po word width
   localparam int NWORDS  = 6;                // words per frame, MS word first
   localparam int M       = 163;              // field degree / product width
   localparam int PAD     = 5;                // LSB padding bits dropped
   localparam int FRAME_W = NWORDS * WORD_W;  // assembled frame width (192)
   localparam int CNT_W   = $clog2(NWORDS + 1);
   localparam int FCNT_W  = 16;               // delivered-frame counter width

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_COLLECT = 2'd1,
      ST_DRAIN   = 2'd2
   } state_t;

endpackage

`default_nettype wire

// File: rtl/gf163_result_collector_if.sv
// ============================================================================
//  Module   : gf163_result_collector_if
//  Purpose  : Bundles the multiplier word stream, the product valid/ready
//             handshake and the status flags of the result collector.
//  Ports    : po_in, ctro_in, res_ready        (into collector)
//             res_data, res_valid, frame_err,
//             overflow, frame_cnt              (out of collector)
//  Modports : master - the environment driving the stream / consuming results
//             slave  - the collector itself
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

interface gf163_result_collector_if;
   import gf163_result_collector_pkg::*;

   logic [WORD_W-1:0] po_in;
   logic              ctro_in;
   logic [M-1:0]      res_data;
   logic              res_valid;
   logic              res_ready;
   logic              frame_err;
   logic              overflow;
   logic [FCNT_W-1:0] frame_cnt;

   modport master (
      output po_in, ctro_in, res_ready,
      input  res_data, res_valid, frame_err, overflow, frame_cnt
   );

   modport slave (
      input  po_in, ctro_in, res_ready,
      output res_data, res_valid, frame_err, overflow, frame_cnt
   );

endinterface

`default_nettype wire

// File: rtl/gf163_result_collector_word_assembler.sv
// ============================================================================
//  Module   : gf163_word_assembler
//  Purpose  : Shift register plus word counter. Shifts one word in per
//             cap_en cycle and strobes done on the cycle that supplies the
//             last word of a frame; the completed product is presented
//             combinationally on that same cycle.
//  Ports    : clk, rstn (async, active-low)
//             cap_en     in  shift word_in in this cycle
//             clr        in  discard partial frame (counter back to 0)
//             word_in    in  WORD_W data word
//             frame_data out product bits frame[M+PAD-1:PAD] incl. word_in
//             done       out this capture completes the frame
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module gf163_word_assembler
   import gf163_result_collector_pkg::*;
(
   input  logic              clk,
   input  logic              rstn,
   input  logic              cap_en,
   input  logic              clr,
   input  logic [WORD_W-1:0] word_in,
   output logic [M-1:0]      frame_data,
   output logic              done
);

   // Only the first NWORDS-1 words need storing; the last word is taken
   // straight from word_in on the completing edge.
   logic [FRAME_W-WORD_W-1:0] sreg_q, sreg_d;
   logic [CNT_W-1:0]          cnt_q,  cnt_d;
   logic [FRAME_W-1:0]        frame_nxt;
   logic                      unused_hi_bits;

   assign frame_nxt      = {sreg_q, word_in};
   assign frame_data     = frame_nxt[M+PAD-1:PAD];
   assign unused_hi_bits = ^frame_nxt[FRAME_W-1:M+PAD];
   assign done           = cap_en && (cnt_q == CNT_W'(NWORDS - 1));

   always_comb begin
      sreg_d = sreg_q;
      cnt_d  = cnt_q;
      if (clr) begin
         cnt_d = '0;
      end else if (cap_en) begin
         sreg_d = frame_nxt[FRAME_W-WORD_W-1:0];
         cnt_d  = done ? '0 : cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         sreg_q <= '0;
         cnt_q  <= '0;
      end else begin
         sreg_q <= sreg_d;
         cnt_q  <= cnt_d;
      end
   end

endmodule

`default_nettype wire

// File: rtl/gf163_result_collector.sv
// ============================================================================
//  Module   : gf163_result_collector
//  Purpose  : Deserialises the GF(2^163) multiplier po/ctro word stream into
//             one 163-bit product, holds it in a single output slot behind a
//             valid/ready handshake, and flags short and dropped frames.
//  Ports    : clk   in  rising-edge clock
//             rstn  in  asynchronous active-low reset
//             bus   slave modport of gf163_result_collector_if
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module gf163_result_collector
   import gf163_result_collector_pkg::*;
(
   input  logic                     clk,
   input  logic                     rstn,
   gf163_result_collector_if.slave  bus
);

   state_t            state_q,     state_d;
   logic [M-1:0]      res_data_q,  res_data_d;
   logic              res_valid_q, res_valid_d;
   logic              frame_err_q, frame_err_d;
   logic              overflow_q,  overflow_d;
   logic [FCNT_W-1:0] frame_cnt_q, frame_cnt_d;

   logic              cap_en;
   logic              clr;
   logic              done;
   logic [M-1:0]      frame_data;

   // Words arriving while draining the tail of an over-long burst are ignored.
   assign cap_en = bus.ctro_in && (state_q != ST_DRAIN);
   // ctro dropping mid-frame throws away the partial frame.
   assign clr    = (state_q == ST_COLLECT) && !bus.ctro_in;

   gf163_word_assembler u_asm (
      .clk        (clk),
      .rstn       (rstn),
      .cap_en     (cap_en),
      .clr        (clr),
      .word_in    (bus.po_in),
      .frame_data (frame_data),
      .done       (done)
   );

   // Next-state logic
   always_comb begin
      state_d     = state_q;
      frame_err_d = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (bus.ctro_in) begin
               state_d = done ? ST_DRAIN : ST_COLLECT;
            end
         end
         ST_COLLECT: begin
            if (bus.ctro_in) begin
               if (done) begin
                  state_d = ST_DRAIN;
               end
            end else begin
               frame_err_d = 1'b1;
               state_d     = ST_IDLE;
            end
         end
         ST_DRAIN: begin
            if (!bus.ctro_in) begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Output slot: an accept and a new load may coincide on the same edge,
   // in which case valid stays high with the new product.
   always_comb begin
      res_data_d  = res_data_q;
      res_valid_d = res_valid_q && !bus.res_ready;
      overflow_d  = overflow_q;
      frame_cnt_d = frame_cnt_q;
      if (done) begin
         if (!res_valid_q || bus.res_ready) begin
            res_data_d  = frame_data;
            res_valid_d = 1'b1;
            frame_cnt_d = frame_cnt_q + 1'b1;
         end else begin
            overflow_d  = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q     <= ST_IDLE;
         res_data_q  <= '0;
         res_valid_q <= 1'b0;
         frame_err_q <= 1'b0;
         overflow_q  <= 1'b0;
         frame_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         res_data_q  <= res_data_d;
         res_valid_q <= res_valid_d;
         frame_err_q <= frame_err_d;
         overflow_q  <= overflow_d;
         frame_cnt_q <= frame_cnt_d;
      end
   end

   assign bus.res_data  = res_data_q;
   assign bus.res_valid = res_valid_q;
   assign bus.frame_err = frame_err_q;
   assign bus.overflow  = overflow_q;
   assign bus.frame_cnt = frame_cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_gf163_result_collector.sv
// ============================================================================
//  Module   : tb_gf163_result_collector
//  Purpose  : Self-checking bench for gf163_result_collector. A stimulus
//             table and directed sequences are followed by random traffic;
//             every cycle is compared against a burst-level reference model.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_gf163_result_collector;
   import gf163_result_collector_pkg::*;

   logic clk  = 1'b0;
   logic rstn = 1'b0;
   always #5 clk = ~clk;

   gf163_result_collector_if bus ();

   gf163_result_collector dut (
      .clk  (clk),
      .rstn (rstn),
      .bus  (bus)
   );

   int checks = 0;
   int errors = 0;

   // ---------------- reference model ----------------
   // A frame is the first NWORDS words of a ctro-high burst; a burst that ends
   // with fewer words is an error; extra words in a burst are ignored.
   logic [WORD_W-1:0] m_words[$];
   bit                m_burst_done;
   logic [M-1:0]      m_data;
   bit                m_valid, m_err, m_ovf;
   logic [15:0]       m_cnt;

   function automatic logic [M-1:0] product_of(input logic [WORD_W-1:0] w[NWORDS]);
      logic [FRAME_W-1:0] f;
      f = '0;
      for (int i = 0; i < NWORDS; i++)
         f = (f << WORD_W) | FRAME_W'(w[i]);
      product_of = f[M+PAD-1:PAD];
   endfunction

   task automatic model_reset();
      m_words.delete();
      m_burst_done = 0;
      m_data = '0;
      m_valid = 0; m_err = 0; m_ovf = 0;
      m_cnt = '0;
   endtask

   task automatic model_update(input bit c, input logic [WORD_W-1:0] p, input bit r);
      bit complete;
      logic [WORD_W-1:0] w[NWORDS];
      complete = 0;
      m_err = 0;
      if (c) begin
         if (!m_burst_done) begin
            m_words.push_back(p);
            if (m_words.size() == NWORDS) begin
               complete = 1;
               for (int i = 0; i < NWORDS; i++) w[i] = m_words[i];
               m_words.delete();
               m_burst_done = 1;
            end
         end
      end else begin
         if (m_words.size() != 0) m_err = 1;
         m_words.delete();
         m_burst_done = 0;
      end
      if (complete) begin
         if (!m_valid || r) begin
            m_data  = product_of(w);
            m_valid = 1;
            m_cnt   = m_cnt + 16'd1;
         end else begin
            m_ovf = 1;
         end
      end else if (m_valid && r) begin
         m_valid = 0;
      end
   endtask

   // ---------------- checking ----------------
   task automatic chk(input string name, input logic [M-1:0] act, input logic [M-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic compare_model(input string tag);
      chk({tag, ".res_valid"}, M'(bus.res_valid), M'(m_valid));
      chk({tag, ".res_data"},  bus.res_data,      m_data);
      chk({tag, ".frame_err"}, M'(bus.frame_err), M'(m_err));
      chk({tag, ".overflow"},  M'(bus.overflow),  M'(m_ovf));
      chk({tag, ".frame_cnt"}, M'(bus.frame_cnt), M'(m_cnt));
   endtask

   task automatic step(input bit c, input logic [WORD_W-1:0] p, input bit r, input string tag);
      bus.ctro_in   = c;
      bus.po_in     = p;
      bus.res_ready = r;
      @(posedge clk);
      model_update(c, p, r);
      @(negedge clk);
      compare_model(tag);
   endtask

   task automatic do_reset(input string tag);
      #1;
      rstn = 1'b0;
      bus.ctro_in = 1'b0; bus.po_in = '0; bus.res_ready = 1'b0;
      model_reset();
      #2;
      compare_model(tag);
      chk({tag, ".all_zero"}, M'({bus.res_valid, bus.frame_err, bus.overflow, bus.frame_cnt}) | bus.res_data, '0);
      @(negedge clk);
      rstn = 1'b1;
   endtask

   // ---------------- stimulus table ----------------
   typedef struct {
      bit                c;
      logic [WORD_W-1:0] p;
      bit                r;
      bit                e_valid;
      bit                e_err;
      bit                e_ovf;
      logic [15:0]       e_cnt;
      logic [M-1:0]      e_data;
   } vec_t;

   vec_t tbl[13];
   logic [M-1:0] k1;
   logic [WORD_W-1:0] fa[NWORDS], fb[NWORDS], fc[9];

   initial begin
      bus.ctro_in = 1'b0; bus.po_in = '0; bus.res_ready = 1'b0;
      model_reset();
      k1 = (163'h7 << 155) | 163'h1;

      tbl[0]  = '{1, 32'h7,  0, 0, 0, 0, 16'd0, 163'h0};
      tbl[1]  = '{1, 32'h0,  0, 0, 0, 0, 16'd0, 163'h0};
      tbl[2]  = '{1, 32'h0,  0, 0, 0, 0, 16'd0, 163'h0};
      tbl[3]  = '{1, 32'h0,  0, 0, 0, 0, 16'd0, 163'h0};
      tbl[4]  = '{1, 32'h0,  0, 0, 0, 0, 16'd0, 163'h0};
      tbl[5]  = '{1, 32'h20, 0, 1, 0, 0, 16'd1, k1};
      tbl[6]  = '{0, 32'h0,  1, 0, 0, 0, 16'd1, k1};
      tbl[7]  = '{1, 32'hA5A5A5A5, 0, 0, 0, 0, 16'd1, k1};
      tbl[8]  = '{1, 32'h12345678, 0, 0, 0, 0, 16'd1, k1};
      tbl[9]  = '{1, 32'hDEADBEEF, 0, 0, 0, 0, 16'd1, k1};
      tbl[10] = '{1, 32'hCAFEF00D, 0, 0, 0, 0, 16'd1, k1};
      tbl[11] = '{0, 32'h0,  0, 0, 1, 0, 16'd1, k1};
      tbl[12] = '{0, 32'h0,  0, 0, 0, 0, 16'd1, k1};

      repeat (2) @(negedge clk);
      compare_model("por");
      rstn = 1'b1;

      // Test 1 and 2: basic frame, accept, short frame
      for (int i = 0; i < 13; i++) begin
         step(tbl[i].c, tbl[i].p, tbl[i].r, $sformatf("tbl%0d", i));
         chk($sformatf("tbl%0d.valid", i), M'(bus.res_valid), M'(tbl[i].e_valid));
         chk($sformatf("tbl%0d.err", i),   M'(bus.frame_err), M'(tbl[i].e_err));
         chk($sformatf("tbl%0d.ovf", i),   M'(bus.overflow),  M'(tbl[i].e_ovf));
         chk($sformatf("tbl%0d.cnt", i),   M'(bus.frame_cnt), M'(tbl[i].e_cnt));
         chk($sformatf("tbl%0d.data", i),  bus.res_data,      tbl[i].e_data);
      end

      for (int i = 0; i < NWORDS; i++) begin
         fa[i] = $urandom();
         fb[i] = $urandom();
      end
      for (int i = 0; i < 9; i++) fc[i] = $urandom();

      // Test 3: two frames with no consumer -> second dropped
      do_reset("rst3");
      for (int i = 0; i < NWORDS; i++) step(1, fa[i], 0, "t3a");
      step(0, '0, 0, "t3gap");
      for (int i = 0; i < NWORDS; i++) step(1, fb[i], 0, "t3b");
      chk("t3.ovf",  M'(bus.overflow),  M'(1));
      chk("t3.cnt",  M'(bus.frame_cnt), M'(1));
      chk("t3.data", bus.res_data,      product_of(fa));
      step(0, '0, 1, "t3pop");
      chk("t3.popped", M'(bus.res_valid), M'(0));

      // Test 4: accept and reload on the same edge
      do_reset("rst4");
      for (int i = 0; i < NWORDS; i++) step(1, fa[i], 0, "t4a");
      step(0, '0, 0, "t4gap");
      for (int i = 0; i < NWORDS; i++) step(1, fb[i], (i == NWORDS - 1), "t4b");
      chk("t4.valid", M'(bus.res_valid), M'(1));
      chk("t4.data",  bus.res_data,      product_of(fb));
      chk("t4.ovf",   M'(bus.overflow),  M'(0));
      chk("t4.cnt",   M'(bus.frame_cnt), M'(2));

      // Test 5: over-long burst, only first NWORDS words used
      step(0, '0, 1, "t5pop");
      for (int i = 0; i < 9; i++) step(1, fc[i], 0, "t5");
      step(0, '0, 0, "t5end");
      chk("t5.cnt",  M'(bus.frame_cnt), M'(3));
      chk("t5.data", bus.res_data,      product_of(fc[0:NWORDS-1]));
      chk("t5.err",  M'(bus.frame_err), M'(0));

      // Test 6: reset mid-frame, then a clean frame
      step(0, '0, 1, "t6pop");
      for (int i = 0; i < 3; i++) step(1, fb[i], 0, "t6part");
      do_reset("rst6");
      for (int i = 0; i < NWORDS; i++) step(1, fa[i], 0, "t6");
      step(0, '0, 0, "t6end");
      chk("t6.data", bus.res_data,      product_of(fa));
      chk("t6.cnt",  M'(bus.frame_cnt), M'(1));

      // Random traffic against the model
      do_reset("rstr");
      for (int n = 0; n < 800; n++) begin
         step(($urandom_range(0, 9) < 8), $urandom(), ($urandom_range(0, 3) != 0), "rnd");
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
